// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencer.
package pipe_ctrl_pkg;

  // Stall vector bit positions.
  localparam int unsigned StallPc   = 0;
  localparam int unsigned StallIfId = 1;
  localparam int unsigned StallIdEx = 2;
  localparam int unsigned StallExMem = 3;
  localparam int unsigned StallMemWb = 4;
  localparam int unsigned StallWb   = 5;

  // Stall vector patterns; each higher-priority pattern subsumes the lower ones.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef enum logic [0:0] {
    StIdle,
    StWaitIf
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear.
module pipe_ctrl_sat_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] q_o
);

  logic [CNT_W-1:0] q_d, q_q;

  // Next count: hold once all-ones is reached instead of wrapping.
  always_comb begin
    q_d = q_q;
    if (en_i && inc_i && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests with EX redirects and
// defers a redirect while IF still has a fetch outstanding.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rdy_i,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_mem_i,
  input  logic              if_busy_i,
  input  logic              ex_jump_taken_i,
  input  logic [ADDR_W-1:0] ex_jump_target_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic [CNT_W-1:0]  cnt_stall_cycles_o,
  output logic [CNT_W-1:0]  cnt_flushes_o
);

  pipe_state_e       state_d, state_q;
  logic [ADDR_W-1:0] target_d, target_q;
  logic [CNT_W-1:0]  cnt_stall_q, cnt_flush_q;

  // State and deferred-target registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next state: rdy low or a MEM stall freezes the sequencer.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (rdy_i && !stallreq_mem_i) begin
      unique case (state_q)
        StIdle: begin
          if (ex_jump_taken_i && if_busy_i) begin
            state_d  = StWaitIf;
            target_d = ex_jump_target_i;
          end
        end
        StWaitIf: begin
          if (!if_busy_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs: combinational in inputs and state, forced to zero under reset.
  always_comb begin
    stall_o          = STALL_NONE;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_addr_o  = '0;
    if (rst_i) begin
      stall_o = STALL_NONE;
    end else if (!rdy_i) begin
      stall_o = STALL_ALL;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (stallreq_mem_i) begin
            // EX re-presents the jump once MEM completes.
            stall_o = STALL_MEM;
          end else if (ex_jump_taken_i) begin
            flush_o = 1'b1;
            if (if_busy_i) begin
              stall_o = STALL_IF;
            end else begin
              redirect_valid_o = 1'b1;
              redirect_addr_o  = ex_jump_target_i;
            end
          end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
          end else if (stallreq_if_i) begin
            stall_o = STALL_IF;
          end
        end
        StWaitIf: begin
          flush_o = 1'b1;
          if (stallreq_mem_i) begin
            stall_o = STALL_MEM;
          end else if (if_busy_i) begin
            stall_o = STALL_IF;
          end else begin
            redirect_valid_o = 1'b1;
            redirect_addr_o  = target_q;
          end
        end
        default: stall_o = STALL_NONE;
      endcase
    end
  end

  pipe_ctrl_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt_stall (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (rdy_i),
    .inc_i(stall_o[StallPc]),
    .q_o  (cnt_stall_q)
  );

  pipe_ctrl_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt_flush (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (rdy_i),
    .inc_i(redirect_valid_o),
    .q_o  (cnt_flush_q)
  );

  assign cnt_stall_cycles_o = rst_i ? '0 : cnt_stall_q;
  assign cnt_flushes_o      = rst_i ? '0 : cnt_flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second CNT_W=4 instance checks saturation.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst, rdy, sreq_if, sreq_id, sreq_mem, if_busy, jmp;
  logic [31:0] jmp_tgt;
  logic [5:0]  stall;
  logic        flush, redir;
  logic [31:0] redir_addr, cnt_stall, cnt_flush;
  logic [5:0]  stall4;
  logic        flush4, redir4;
  logic [31:0] redir_addr4;
  logic [3:0]  cnt_stall4, cnt_flush4;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) u_dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .rdy_i             (rdy),
    .stallreq_if_i     (sreq_if),
    .stallreq_id_i     (sreq_id),
    .stallreq_mem_i    (sreq_mem),
    .if_busy_i         (if_busy),
    .ex_jump_taken_i   (jmp),
    .ex_jump_target_i  (jmp_tgt),
    .stall_o           (stall),
    .flush_o           (flush),
    .redirect_valid_o  (redir),
    .redirect_addr_o   (redir_addr),
    .cnt_stall_cycles_o(cnt_stall),
    .cnt_flushes_o     (cnt_flush)
  );

  pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) u_dut4 (
    .clk_i             (clk),
    .rst_i             (rst),
    .rdy_i             (rdy),
    .stallreq_if_i     (sreq_if),
    .stallreq_id_i     (sreq_id),
    .stallreq_mem_i    (sreq_mem),
    .if_busy_i         (if_busy),
    .ex_jump_taken_i   (jmp),
    .ex_jump_target_i  (jmp_tgt),
    .stall_o           (stall4),
    .flush_o           (flush4),
    .redirect_valid_o  (redir4),
    .redirect_addr_o   (redir_addr4),
    .cnt_stall_cycles_o(cnt_stall4),
    .cnt_flushes_o     (cnt_flush4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving time to change inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1'b1; sreq_if = 1'b0; sreq_id = 1'b0; sreq_mem = 1'b0;
    if_busy = 1'b0; jmp = 1'b0; jmp_tgt = 32'h0;
  endtask

  initial begin
    clear_inputs();
    // 1. Reset dominates every input.
    rst = 1'b1; sreq_if = 1'b1; sreq_id = 1'b1; sreq_mem = 1'b1;
    if_busy = 1'b1; jmp = 1'b1; jmp_tgt = 32'hABCD;
    tick(); tick();
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_flush", 64'(flush), 64'h0);
    chk("rst_redir", 64'(redir), 64'h0);
    chk("rst_addr", 64'(redir_addr), 64'h0);
    chk("rst_cnt_stall", 64'(cnt_stall), 64'h0);
    chk("rst_cnt_flush", 64'(cnt_flush), 64'h0);
    rst = 1'b0; clear_inputs();
    tick(); tick();
    chk("idle_cnt_stall", 64'(cnt_stall), 64'h0);
    chk("idle_stall", 64'(stall), 64'h0);

    // 2. ID hazard for three cycles.
    sreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("id_stall", 64'(stall), 64'h07);
      tick();
    end
    sreq_id = 1'b0; settle();
    chk("id_cnt", 64'(cnt_stall), 64'd3);

    // 3. MEM stall outranks ID and suppresses the jump.
    sreq_mem = 1'b1; sreq_id = 1'b1; jmp = 1'b1; if_busy = 1'b1; jmp_tgt = 32'h5555;
    settle();
    chk("mem_stall", 64'(stall), 64'h1F);
    chk("mem_flush", 64'(flush), 64'h0);
    chk("mem_redir", 64'(redir), 64'h0);
    tick(); clear_inputs(); settle();
    chk("mem_state_idle", 64'(flush), 64'h0);
    chk("mem_cnt", 64'(cnt_stall), 64'd4);

    // 4. Immediate redirect; ID request is masked.
    jmp = 1'b1; jmp_tgt = 32'h0000_1040; sreq_id = 1'b1; settle();
    chk("jmp_flush", 64'(flush), 64'h1);
    chk("jmp_redir", 64'(redir), 64'h1);
    chk("jmp_addr", 64'(redir_addr), 64'h1040);
    chk("jmp_stall", 64'(stall), 64'h0);
    tick(); clear_inputs(); settle();
    chk("jmp_cnt_flush", 64'(cnt_flush), 64'd1);
    chk("jmp_redir_off", 64'(redir), 64'h0);
    chk("jmp_cnt_stall", 64'(cnt_stall), 64'd4);

    // 5. Deferred redirect while IF is busy; target input moves meanwhile.
    jmp = 1'b1; jmp_tgt = 32'h2000; if_busy = 1'b1; settle();
    chk("def0_flush", 64'(flush), 64'h1);
    chk("def0_stall", 64'(stall), 64'h03);
    chk("def0_redir", 64'(redir), 64'h0);
    tick();
    jmp_tgt = 32'h3000;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("defw_flush", 64'(flush), 64'h1);
      chk("defw_stall", 64'(stall), 64'h03);
      chk("defw_redir", 64'(redir), 64'h0);
      tick();
    end
    if_busy = 1'b0; jmp = 1'b0; settle();
    chk("defr_redir", 64'(redir), 64'h1);
    chk("defr_addr", 64'(redir_addr), 64'h2000);
    chk("defr_flush", 64'(flush), 64'h1);
    chk("defr_stall", 64'(stall), 64'h0);
    tick(); clear_inputs(); settle();
    chk("defr_once", 64'(redir), 64'h0);
    chk("defr_idle", 64'(flush), 64'h0);
    chk("defr_cnt_flush", 64'(cnt_flush), 64'd2);
    chk("defr_cnt_stall", 64'(cnt_stall), 64'd7);

    // 6a. rdy low while waiting on IF freezes everything.
    jmp = 1'b1; jmp_tgt = 32'h4000; if_busy = 1'b1;
    tick(); jmp = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("frz_stall", 64'(stall), 64'h3F);
      chk("frz_flush", 64'(flush), 64'h0);
      chk("frz_redir", 64'(redir), 64'h0);
      tick();
    end
    chk("frz_cnt_stall", 64'(cnt_stall), 64'd8);
    rdy = 1'b1; settle();
    chk("res_flush", 64'(flush), 64'h1);
    chk("res_stall", 64'(stall), 64'h03);
    tick(); if_busy = 1'b0; settle();
    chk("res_redir", 64'(redir), 64'h1);
    chk("res_addr", 64'(redir_addr), 64'h4000);
    tick(); clear_inputs(); settle();
    chk("res_cnt_flush", 64'(cnt_flush), 64'd3);
    chk("res_cnt_stall", 64'(cnt_stall), 64'd9);

    // 6b. Reset in WAIT_IF discards the pending redirect.
    jmp = 1'b1; jmp_tgt = 32'h5000; if_busy = 1'b1;
    tick(); clear_inputs();
    rst = 1'b1; settle();
    chk("rstw_redir", 64'(redir), 64'h0);
    chk("rstw_flush", 64'(flush), 64'h0);
    tick(); rst = 1'b0; settle();
    chk("rstw_idle_flush", 64'(flush), 64'h0);
    chk("rstw_idle_redir", 64'(redir), 64'h0);
    chk("rstw_cnt_flush", 64'(cnt_flush), 64'h0);
    chk("rstw_cnt_stall", 64'(cnt_stall), 64'h0);

    // 6c. Saturation on the 4-bit counter after 20 stall cycles.
    sreq_if = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    sreq_if = 1'b0; settle();
    chk("sat_cnt4", 64'(cnt_stall4), 64'hF);
    chk("sat_cnt32", 64'(cnt_stall), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
